// File: rtl/ticket_call_scheduler.sv
// Ticket FIFO, officer arbiter and paced call announcement (IDLE -> CALL -> HOLD).
// Define FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module ticket_call_scheduler #(
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned TICKET_MAX  = 99,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               take_ticket,
    input  logic [3:0]                         officer_ready,
    output logic [6:0]                         issued_ticket,
    output logic                               issue_valid,
    output logic                               issue_reject,
    output logic [6:0]                         call_ticket,
    output logic [1:0]                         call_officer,
    output logic                               call_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   waiting_count,
    output logic                               queue_full,
    output logic                               queue_empty
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CALL, HOLD} state_t;

    state_t        state, state_next;
    logic [6:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [HW-1:0] hold_cnt;
    logic          push, pop, hold_done;
    logic [6:0]    next_ticket;
    logic [1:0]    grant;
    logic          found;

    // Pop only sees entries present before this edge, so a same-edge push to an empty queue waits.
    assign push        = take_ticket && !queue_full;
    assign pop         = (state == IDLE) && (|officer_ready) && !queue_empty;
    assign hold_done   = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign next_ticket = (issued_ticket == 7'(TICKET_MAX)) ? 7'd1 : issued_ticket + 7'd1;

`ifdef FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && officer_ready[2'(i)]) begin
                grant = 2'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [1:0] rr_ptr, idx;

    // Search starts one past the last granted officer, so it is visited last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && officer_ready[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= 2'd3;
        else if (pop) rr_ptr <= grant;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = CALL;
            CALL:    state_next = HOLD;
            HOLD:    if (hold_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        call_valid  = (state == CALL);
        queue_full  = (waiting_count == CW'(QUEUE_DEPTH));
        queue_empty = (waiting_count == '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= next_ticket;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            waiting_count <= '0;
            issued_ticket <= '0;
            issue_valid   <= 1'b0;
            issue_reject  <= 1'b0;
            call_ticket   <= '0;
            call_officer  <= '0;
            hold_cnt      <= '0;
        end else begin
            issue_valid  <= push;
            issue_reject <= take_ticket && queue_full;
            if (push) begin
                wr_ptr        <= wr_ptr + AW'(1);
                issued_ticket <= next_ticket;
            end
            if (pop) begin
                call_ticket  <= mem[rd_ptr];
                call_officer <= grant;
                rd_ptr       <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   waiting_count <= waiting_count + CW'(1);
                2'b01:   waiting_count <= waiting_count - CW'(1);
                default: waiting_count <= waiting_count;
            endcase
            if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
            else               hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ticket_call_scheduler.sv
// Bench for ticket_call_scheduler: queue-based reference model checked every cycle, plus directed literals.
module tb_ticket_call_scheduler;

    localparam int DEPTH = 8;
    localparam int TMAX  = 99;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          take_ticket = 1'b0;
    logic [3:0]    officer_ready = 4'b0000;
    logic [6:0]    issued_ticket;
    logic          issue_valid, issue_reject;
    logic [6:0]    call_ticket;
    logic [1:0]    call_officer;
    logic          call_valid;
    logic [CW-1:0] waiting_count;
    logic          queue_full, queue_empty;

    int checks = 0;
    int errors = 0;

    ticket_call_scheduler #(
        .QUEUE_DEPTH(DEPTH),
        .TICKET_MAX (TMAX),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .take_ticket  (take_ticket),
        .officer_ready(officer_ready),
        .issued_ticket(issued_ticket),
        .issue_valid  (issue_valid),
        .issue_reject (issue_reject),
        .call_ticket  (call_ticket),
        .call_officer (call_officer),
        .call_valid   (call_valid),
        .waiting_count(waiting_count),
        .queue_full   (queue_full),
        .queue_empty  (queue_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a ticket queue, a busy countdown after each call, and the last-served officer.
    int q[$];
    int m_last = 0, m_call_t = 0, m_call_o = 0, m_busy = 0, m_rr = 3;
    bit m_iv = 0, m_rej = 0, m_cv = 0, m_valid = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        logic [1:0] j;
`ifdef FIXED_PRIORITY_EN
        for (int k = 0; k < 4; k++) begin
            j = 2'(k);
            if (r[j]) return k;
        end
`else
        for (int k = 1; k <= 4; k++) begin
            j = 2'((p + k) % 4);
            if (r[j]) return (p + k) % 4;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_last = 0; m_call_t = 0; m_call_o = 0; m_busy = 0; m_rr = 3;
            m_iv = 0; m_rej = 0; m_cv = 0; m_valid = 1;
        end else begin
            int  size0;
            size0 = q.size();
            m_iv = 0; m_rej = 0; m_cv = 0;
            if (m_busy != 0) m_busy--;
            else if (officer_ready != 4'b0000 && size0 != 0) begin
                m_call_o = pick(officer_ready, m_rr);
                m_rr     = m_call_o;
                m_call_t = q.pop_front();
                m_cv     = 1;
                m_busy   = HOLD + 1;
            end
            if (take_ticket) begin
                if (size0 == DEPTH) m_rej = 1;
                else begin
                    m_last = (m_last == TMAX) ? 1 : m_last + 1;
                    q.push_back(m_last);
                    m_iv = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("issued_ticket", 32'(issued_ticket), 32'(m_last));
            chk("issue_valid",   32'(issue_valid),   32'(m_iv));
            chk("issue_reject",  32'(issue_reject),  32'(m_rej));
            chk("call_ticket",   32'(call_ticket),   32'(m_call_t));
            chk("call_officer",  32'(call_officer),  32'(m_call_o));
            chk("call_valid",    32'(call_valid),    32'(m_cv));
            chk("waiting_count", 32'(waiting_count), 32'(q.size()));
            chk("queue_full",    32'(queue_full),    32'(q.size() == DEPTH));
            chk("queue_empty",   32'(queue_empty),   32'(q.size() == 0));
        end
    end

    int rec_n;
    int rec_cyc[8];
    int rec_tk[8];
    int rec_of[8];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; take_ticket = 1'b0; officer_ready = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic take_one();
        @(negedge clk);
        take_ticket = 1'b1;
        @(negedge clk);
        take_ticket = 1'b0;
    endtask

    task automatic watch(input int n);
        rec_n = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (call_valid && rec_n < 8) begin
                rec_cyc[rec_n] = c;
                rec_tk[rec_n]  = int'(call_ticket);
                rec_of[rec_n]  = int'(call_officer);
                rec_n++;
            end
        end
    endtask

    initial begin
        // Reset state and three issues
        do_reset();
        chk("rst_waiting", 32'(waiting_count), 0);
        chk("rst_empty",   32'(queue_empty),   1);
        chk("rst_call_tk", 32'(call_ticket),   0);
        for (int i = 1; i <= 3; i++) begin
            take_one();
            chk("issue_num", 32'(issued_ticket), 32'(i));
            chk("issue_pulse", 32'(issue_valid), 1);
        end
        chk("wc_after3",    32'(waiting_count), 3);
        chk("empty_after3", 32'(queue_empty),   0);

        // Two queued, ready 0101 held: call spacing and officer rotation
        do_reset();
        take_one();
        take_one();
        officer_ready = 4'b0101;
        watch(20);
        officer_ready = 4'b0000;
        chk("calls_seen", 32'(rec_n), 2);
        if (rec_n == 2) begin
            chk("call1_cycle", 32'(rec_cyc[0]), 1);
            chk("call_spacing", 32'(rec_cyc[1] - rec_cyc[0]), 32'(HOLD + 2));
            chk("call1_ticket", 32'(rec_tk[0]), 1);
            chk("call1_officer", 32'(rec_of[0]), 0);
            chk("call2_ticket", 32'(rec_tk[1]), 2);
`ifdef FIXED_PRIORITY_EN
            chk("call2_officer", 32'(rec_of[1]), 0);
`else
            chk("call2_officer", 32'(rec_of[1]), 2);
`endif
        end

        // Fill, reject on ninth, then same-edge pop and take while full
        do_reset();
        for (int i = 0; i < 8; i++) take_one();
        chk("full_set", 32'(queue_full), 1);
        take_one();
        chk("ninth_reject", 32'(issue_reject), 1);
        chk("ninth_no_valid", 32'(issue_valid), 0);
        chk("ninth_issued", 32'(issued_ticket), 8);
        @(negedge clk);
        take_ticket = 1'b1; officer_ready = 4'b0001;
        @(negedge clk);
        take_ticket = 1'b0; officer_ready = 4'b0000;
        chk("full_pop_reject", 32'(issue_reject), 1);
        chk("full_pop_wc", 32'(waiting_count), 7);
        chk("full_pop_call", 32'(call_ticket), 1);
        repeat (8) @(negedge clk);

        // Wrap after TICKET_MAX
        do_reset();
        officer_ready = 4'b1111;
        for (int i = 0; i < TMAX; i++) begin
            take_one();
            repeat (6) @(negedge clk);
        end
        chk("issued_max", 32'(issued_ticket), 32'(TMAX));
        take_one();
        chk("wrap_to_1", 32'(issued_ticket), 1);
        officer_ready = 4'b0000;
        repeat (8) @(negedge clk);

        // Take and grant on the same edge with 3 queued
        do_reset();
        for (int i = 0; i < 3; i++) take_one();
        @(negedge clk);
        take_ticket = 1'b1; officer_ready = 4'b0010;
        @(negedge clk);
        take_ticket = 1'b0; officer_ready = 4'b0000;
        chk("same_edge_wc", 32'(waiting_count), 3);
        chk("same_edge_tk", 32'(call_ticket), 1);
        chk("same_edge_of", 32'(call_officer), 1);
        chk("same_edge_iss", 32'(issued_ticket), 4);

        // Reset during HOLD with 4 queued, with a simultaneous take
        do_reset();
        for (int i = 0; i < 5; i++) take_one();
        officer_ready = 4'b1111;
        @(negedge clk);
        officer_ready = 4'b0000;
        @(negedge clk);
        chk("hold_wc", 32'(waiting_count), 4);
        @(negedge clk);
        reset = 1'b1; take_ticket = 1'b1;
        @(negedge clk);
        reset = 1'b0; take_ticket = 1'b0;
        chk("rst_hold_wc", 32'(waiting_count), 0);
        chk("rst_hold_cv", 32'(call_valid), 0);
        chk("rst_hold_tk", 32'(call_ticket), 0);
        chk("rst_hold_iss", 32'(issued_ticket), 0);

        // All officers ready: arbitration order across three calls
        do_reset();
        for (int i = 0; i < 3; i++) take_one();
        officer_ready = 4'b1111;
        watch(20);
        officer_ready = 4'b0000;
        chk("allready_calls", 32'(rec_n), 3);
        if (rec_n == 3) begin
            chk("allready_of0", 32'(rec_of[0]), 0);
`ifdef FIXED_PRIORITY_EN
            chk("allready_of1", 32'(rec_of[1]), 0);
            chk("allready_of2", 32'(rec_of[2]), 0);
`else
            chk("allready_of1", 32'(rec_of[1]), 1);
            chk("allready_of2", 32'(rec_of[2]), 2);
`endif
            chk("allready_tk2", 32'(rec_tk[2]), 3);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
